// File: rtl/branch_resolve_unit_if.sv
// Request/result bundle between the ALU compare stage, branch_resolve_unit and PC-select.
// The master side drives requests and result acceptance. The slave side is the resolver.
interface branch_resolve_unit_if;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  br_op;
  logic [31:0] pc;
  logic [15:0] imm16;
  logic [25:0] imm26;
  logic [31:0] cmp_s;
  logic [31:0] rs_val;
  logic        out_valid;
  logic        out_ready;
  logic        out_taken;
  logic [31:0] out_target;
  logic        out_err;
  logic        flush;

  modport master (
    output in_valid, br_op, pc, imm16, imm26, cmp_s, rs_val, out_ready,
    input  in_ready, out_valid, out_taken, out_target, out_err, flush
  );

  modport slave (
    input  in_valid, br_op, pc, imm16, imm26, cmp_s, rs_val, out_ready,
    output in_ready, out_valid, out_taken, out_target, out_err, flush
  );
endinterface

// File: rtl/branch_resolve_unit.sv
// MIPS branch/jump resolver: one registered stage with a post-taken flush window.
// Optional macro BRANCH_RESOLVE_STATS_EN adds handoff/taken statistics counters.
module branch_resolve_unit #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [31:0] RESET_PC     = 32'h0000_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  branch_resolve_unit_if.slave  bus
`ifdef BRANCH_RESOLVE_STATS_EN
  ,
  input  logic                  stat_clear,
  output logic [31:0]           stat_total,
  output logic [31:0]           stat_taken
`endif
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] HOLD  = 2'd1;
  localparam logic [1:0] FLUSH = 2'd2;

  localparam logic [2:0] OP_BEQ  = 3'b000;
  localparam logic [2:0] OP_BNE  = 3'b001;
  localparam logic [2:0] OP_BLEZ = 3'b010;
  localparam logic [2:0] OP_BGTZ = 3'b011;
  localparam logic [2:0] OP_BLTZ = 3'b100;
  localparam logic [2:0] OP_BGEZ = 3'b101;
  localparam logic [2:0] OP_J    = 3'b110;

  logic [1:0]  state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;
  logic        taken_reg, taken_next;
  logic        err_reg, err_next;
  logic [31:0] target_reg, target_next;

  logic        accept;
  logic        handoff;
  logic        taken_c;
  logic        err_c;
  logic [31:0] pc4;
  logic [31:0] target_c;
  logic        rs_zero;
  logic        unused_cmp_bits;

  // Only the NEQ bit of the compare word carries information.
  assign unused_cmp_bits = ^bus.cmp_s[31:1];

  assign bus.out_valid  = (state_reg == HOLD);
  assign bus.flush      = (state_reg == FLUSH);
  assign bus.out_taken  = taken_reg;
  assign bus.out_target = target_reg;
  assign bus.out_err    = err_reg;
  assign bus.in_ready   = (state_reg == IDLE) |
                          ((state_reg == HOLD) & bus.out_ready & ~taken_reg);

  assign accept  = bus.in_valid & bus.in_ready;
  assign handoff = bus.out_valid & bus.out_ready;
  assign pc4     = bus.pc + 32'd4;
  assign rs_zero = (bus.rs_val == 32'd0);

  always_comb begin
    taken_c = 1'b0;
    err_c   = 1'b0;
    case (bus.br_op)
      OP_BEQ:  taken_c = ~bus.cmp_s[0];
      OP_BNE:  taken_c = bus.cmp_s[0];
      OP_BLEZ: taken_c = bus.rs_val[31] | rs_zero;
      OP_BGTZ: taken_c = ~bus.rs_val[31] & ~rs_zero;
      OP_BLTZ: taken_c = bus.rs_val[31];
      OP_BGEZ: taken_c = ~bus.rs_val[31];
      OP_J:    taken_c = 1'b1;
      default: err_c   = 1'b1;
    endcase

    if (!taken_c)
      target_c = pc4;
    else if (bus.br_op == OP_J)
      target_c = {pc4[31:28], bus.imm26, 2'b00};
    else
      target_c = pc4 + {{14{bus.imm16[15]}}, bus.imm16, 2'b00};
  end

  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    taken_next  = taken_reg;
    err_next    = err_reg;
    target_next = target_reg;

    case (state_reg)
      HOLD: begin
        if (bus.out_ready) begin
          // Leaving HOLD drops back to the idle target unless a new result replaces it.
          taken_next  = 1'b0;
          target_next = RESET_PC;
          if (taken_reg) begin
            if (FLUSH_CYCLES != 0) begin
              state_next = FLUSH;
              cnt_next   = 4'(FLUSH_CYCLES);
            end else begin
              state_next = IDLE;
            end
          end else if (!accept) begin
            state_next = IDLE;
          end
        end
      end
      FLUSH: begin
        cnt_next = cnt_reg - 4'd1;
        if (cnt_reg == 4'd1)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase

    if (accept) begin
      state_next  = HOLD;
      taken_next  = taken_c;
      err_next    = err_c;
      target_next = target_c;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      cnt_reg    <= 4'd0;
      taken_reg  <= 1'b0;
      err_reg    <= 1'b0;
      target_reg <= RESET_PC;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      taken_reg  <= taken_next;
      err_reg    <= err_next;
      target_reg <= target_next;
    end
  end

`ifdef BRANCH_RESOLVE_STATS_EN
  logic [31:0] total_reg, total_next;
  logic [31:0] tcount_reg, tcount_next;

  // A clear coincident with a handoff still counts that handoff.
  always_comb begin
    total_next  = total_reg + {31'd0, handoff};
    tcount_next = tcount_reg + {31'd0, handoff & taken_reg};
    if (stat_clear) begin
      total_next  = {31'd0, handoff};
      tcount_next = {31'd0, handoff & taken_reg};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      total_reg  <= 32'd0;
      tcount_reg <= 32'd0;
    end else begin
      total_reg  <= total_next;
      tcount_reg <= tcount_next;
    end
  end

  assign stat_total = total_reg;
  assign stat_taken = tcount_reg;
`else
  logic unused_handoff;
  assign unused_handoff = handoff;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Directed self-checking bench for branch_resolve_unit (FLUSH_CYCLES=2, non-zero RESET_PC).
// Stats checks run only when BRANCH_RESOLVE_STATS_EN is defined.
module tb_branch_resolve_unit;
  localparam logic [31:0] RPC = 32'hBFC0_0000;

  logic clk = 1'b0;
  logic reset;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if bus ();

`ifdef BRANCH_RESOLVE_STATS_EN
  logic        stat_clear;
  logic [31:0] stat_total;
  logic [31:0] stat_taken;
`endif

  branch_resolve_unit #(
    .FLUSH_CYCLES (2),
    .RESET_PC     (RPC)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
`ifdef BRANCH_RESOLVE_STATS_EN
    ,
    .stat_clear (stat_clear),
    .stat_total (stat_total),
    .stat_taken (stat_taken)
`endif
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input logic [2:0] op, input logic [31:0] p, input logic [15:0] i16,
                         input logic [25:0] i26, input logic [31:0] c, input logic [31:0] rs);
    bus.br_op  = op;
    bus.pc     = p;
    bus.imm16  = i16;
    bus.imm26  = i26;
    bus.cmp_s  = c;
    bus.rs_val = rs;
  endtask

  // Issue one request with out_ready low; the unit is left holding the result.
  task automatic run_op(input logic [2:0] op, input logic [31:0] p, input logic [15:0] i16,
                        input logic [25:0] i26, input logic [31:0] c, input logic [31:0] rs);
    set_req(op, p, i16, i26, c, rs);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    $display("txn op=%b pc=%h -> valid=%b taken=%b target=%h err=%b",
             op, p, bus.out_valid, bus.out_taken, bus.out_target, bus.out_err);
  endtask

  task automatic drain;
    bit done = 1'b0;
    bus.out_ready = 1'b1;
    bus.in_valid  = 1'b0;
    for (int i = 0; i < 10 && !done; i++) begin
      step();
      if (!bus.out_valid && !bus.flush && bus.in_ready) done = 1'b1;
    end
    total_cnt++;
    if (!done) $display("FAIL drain_timeout: unit did not return to idle within 10 cycles");
    else pass_cnt++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b0;
    set_req(3'b000, 32'd0, 16'd0, 26'd0, 32'd0, 32'd0);
`ifdef BRANCH_RESOLVE_STATS_EN
    stat_clear = 1'b0;
`endif
    step();
    step();
    reset = 1'b0;
    total_cnt++;
    if (bus.out_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", bus.out_valid);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_target !== RPC) $display("FAIL reset_target: got %h want %h", bus.out_target, RPC);
    else pass_cnt++;
    total_cnt++;
    if (bus.flush !== 1'b0 || bus.out_taken !== 1'b0 || bus.out_err !== 1'b0)
      $display("FAIL reset_flags: flush=%b taken=%b err=%b want 000", bus.flush, bus.out_taken, bus.out_err);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL reset_in_ready: got %b want 1", bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_beq_flush;
    set_req(3'b000, 32'h0040_0010, 16'hFFFE, 26'd0, 32'd0, 32'd0);
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    step();
    bus.in_valid = 1'b0;
    $display("txn BEQ pc=00400010 -> taken=%b target=%h", bus.out_taken, bus.out_target);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_taken !== 1'b1)
      $display("FAIL beq_taken: valid=%b taken=%b want 1 1", bus.out_valid, bus.out_taken);
    else pass_cnt++;
    total_cnt++;
    if (bus.out_target !== 32'h0040_000C) $display("FAIL beq_target: got %h want 0040000c", bus.out_target);
    else pass_cnt++;
    total_cnt++;
    if (bus.in_ready !== 1'b0 || bus.flush !== 1'b0)
      $display("FAIL beq_hold_ready: in_ready=%b flush=%b want 0 0", bus.in_ready, bus.flush);
    else pass_cnt++;
    for (int i = 0; i < 2; i++) begin
      step();
      total_cnt++;
      if (bus.flush !== 1'b1 || bus.in_ready !== 1'b0 || bus.out_valid !== 1'b0)
        $display("FAIL beq_flush_%0d: flush=%b in_ready=%b valid=%b want 1 0 0",
                 i, bus.flush, bus.in_ready, bus.out_valid);
      else pass_cnt++;
    end
    step();
    total_cnt++;
    if (bus.flush !== 1'b0 || bus.in_ready !== 1'b1)
      $display("FAIL beq_flush_end: flush=%b in_ready=%b want 0 1", bus.flush, bus.in_ready);
    else pass_cnt++;
  endtask

  task automatic test_back_to_back;
    run_op(3'b001, 32'h0000_0100, 16'h0010, 26'd0, 32'd0, 32'd0);
    // A competing taken request stays asserted and must be ignored while stalled.
    set_req(3'b000, 32'h0000_0300, 16'h0004, 26'd0, 32'd0, 32'd0);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      total_cnt++;
      if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h0000_0104 ||
          bus.out_taken !== 1'b0 || bus.in_ready !== 1'b0)
        $display("FAIL bne_stall_%0d: valid=%b target=%h taken=%b in_ready=%b want 1 00000104 0 0",
                 i, bus.out_valid, bus.out_target, bus.out_taken, bus.in_ready);
      else pass_cnt++;
      step();
    end
    set_req(3'b000, 32'h0000_0200, 16'h0004, 26'd0, 32'd1, 32'd0);
    bus.out_ready = 1'b1;
    #1;
    total_cnt++;
    if (bus.in_ready !== 1'b1) $display("FAIL b2b_in_ready: got %b want 1", bus.in_ready);
    else pass_cnt++;
    step();
    bus.in_valid = 1'b0;
    $display("txn BEQ pc=00000200 b2b -> valid=%b target=%h", bus.out_valid, bus.out_target);
    total_cnt++;
    if (bus.out_valid !== 1'b1 || bus.out_target !== 32'h0000_0204 || bus.out_taken !== 1'b0)
      $display("FAIL b2b_result: valid=%b target=%h taken=%b want 1 00000204 0",
               bus.out_valid, bus.out_target, bus.out_taken);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.flush !== 1'b0 || bus.out_target !== RPC)
      $display("FAIL b2b_idle: valid=%b in_ready=%b flush=%b target=%h want 0 1 0 %h",
               bus.out_valid, bus.in_ready, bus.flush, bus.out_target, RPC);
    else pass_cnt++;
  endtask

  task automatic test_ops;
    run_op(3'b110, 32'hF000_0000, 16'd0, 26'h0123456, 32'd0, 32'd0);
    total_cnt++;
    if (bus.out_taken !== 1'b1 || bus.out_target !== 32'hF048_D158 || bus.out_err !== 1'b0)
      $display("FAIL j_result: taken=%b target=%h err=%b want 1 f048d158 0",
               bus.out_taken, bus.out_target, bus.out_err);
    else pass_cnt++;
    drain();
    run_op(3'b010, 32'h0000_1000, 16'h0010, 26'd0, 32'd0, 32'd0);
    total_cnt++;
    if (bus.out_taken !== 1'b1 || bus.out_target !== 32'h0000_1044)
      $display("FAIL blez_zero: taken=%b target=%h want 1 00001044", bus.out_taken, bus.out_target);
    else pass_cnt++;
    drain();
    run_op(3'b011, 32'h0000_2000, 16'h0010, 26'd0, 32'd0, 32'h8000_0000);
    total_cnt++;
    if (bus.out_taken !== 1'b0 || bus.out_target !== 32'h0000_2004)
      $display("FAIL bgtz_neg: taken=%b target=%h want 0 00002004", bus.out_taken, bus.out_target);
    else pass_cnt++;
    drain();
    run_op(3'b111, 32'h0000_3000, 16'h0010, 26'd0, 32'd0, 32'd0);
    total_cnt++;
    if (bus.out_err !== 1'b1 || bus.out_taken !== 1'b0 || bus.out_target !== 32'h0000_3004)
      $display("FAIL reserved_op: err=%b taken=%b target=%h want 1 0 00003004",
               bus.out_err, bus.out_taken, bus.out_target);
    else pass_cnt++;
    drain();
    run_op(3'b100, 32'h0000_4000, 16'hFFFF, 26'd0, 32'd0, 32'hFFFF_FFFF);
    total_cnt++;
    if (bus.out_taken !== 1'b1 || bus.out_target !== 32'h0000_4000 || bus.out_err !== 1'b0)
      $display("FAIL bltz_err_clear: taken=%b target=%h err=%b want 1 00004000 0",
               bus.out_taken, bus.out_target, bus.out_err);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_wrap_reset;
    run_op(3'b101, 32'hFFFF_FFFC, 16'h0001, 26'd0, 32'd0, 32'd0);
    total_cnt++;
    if (bus.out_taken !== 1'b1 || bus.out_target !== 32'h0000_0004)
      $display("FAIL bgez_wrap: taken=%b target=%h want 1 00000004", bus.out_taken, bus.out_target);
    else pass_cnt++;
    bus.out_ready = 1'b1;
    step();
    total_cnt++;
    if (bus.flush !== 1'b1) $display("FAIL wrap_flush: got %b want 1", bus.flush);
    else pass_cnt++;
    reset = 1'b1;
    step();
    reset = 1'b0;
    total_cnt++;
    if (bus.flush !== 1'b0 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_target !== RPC)
      $display("FAIL flush_reset: flush=%b valid=%b in_ready=%b target=%h want 0 0 1 %h",
               bus.flush, bus.out_valid, bus.in_ready, bus.out_target, RPC);
    else pass_cnt++;
    step();
    total_cnt++;
    if (bus.flush !== 1'b0) $display("FAIL flush_reset_stays: flush=%b want 0", bus.flush);
    else pass_cnt++;
  endtask

`ifdef BRANCH_RESOLVE_STATS_EN
  task automatic test_stats;
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    total_cnt++;
    if (stat_total !== 32'd0 || stat_taken !== 32'd0)
      $display("FAIL stat_clear_idle: total=%0d taken=%0d want 0 0", stat_total, stat_taken);
    else pass_cnt++;
    for (int i = 0; i < 3; i++) begin
      run_op(3'b001, 32'h0000_0500, 16'h0001, 26'd0, 32'd0, 32'd0);
      drain();
    end
    for (int i = 0; i < 2; i++) begin
      run_op(3'b000, 32'h0000_0600, 16'h0001, 26'd0, 32'd0, 32'd0);
      drain();
    end
    total_cnt++;
    if (stat_total !== 32'd5 || stat_taken !== 32'd2)
      $display("FAIL stat_counts: total=%0d taken=%0d want 5 2", stat_total, stat_taken);
    else pass_cnt++;
    run_op(3'b000, 32'h0000_0700, 16'h0001, 26'd0, 32'd0, 32'd0);
    bus.out_ready = 1'b1;
    stat_clear = 1'b1;
    step();
    stat_clear = 1'b0;
    total_cnt++;
    if (stat_total !== 32'd1 || stat_taken !== 32'd1)
      $display("FAIL stat_clear_handoff: total=%0d taken=%0d want 1 1", stat_total, stat_taken);
    else pass_cnt++;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_beq_flush();
    test_back_to_back();
    test_ops();
    test_wrap_reset();
`ifdef BRANCH_RESOLVE_STATS_EN
    test_stats();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
